// File: rtl/apb_led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_led_pkg
// Description : Shared types and constants for the APB LED completer:
//               handshake state encoding, register offsets and CTRL bit
//               positions.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_led_pkg;

    // Handshake state of the APB completer
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Register byte offsets within the 16-byte register window
    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_DATA   = 4'h4;
    localparam logic [3:0] REG_PERIOD = 4'h8;
    localparam logic [3:0] REG_STATUS = 4'hC;

    // CTRL register bit positions
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_BLINK_BIT = 1;

endpackage
`default_nettype wire

// File: rtl/apb_led_blink.sv
`default_nettype none
// ============================================================================
// Module      : apb_led_blink
// Description : Blink engine. Counts cnt from 0 to period-1 and toggles
//               phase on every wrap while enabled.
// Ports       : pclk, presetn (sync, active-low)
//               en, blink_en   - CTRL bits; engine runs when both are set
//               period         - blink half-period in pclk cycles (0 = hold)
//               period_wr      - pulse on a committed PERIOD write
//               phase, cnt     - engine state
// Revision    : 1.0 - initial release
// ============================================================================
module apb_led_blink
    import apb_led_pkg::*;
#(
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    en,
    input  logic                    blink_en,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    period_wr,
    output logic                    phase,
    output logic [PERIOD_WIDTH-1:0] cnt
);

    logic                    phase_q;
    logic                    phase_d;
    logic [PERIOD_WIDTH-1:0] cnt_q;
    logic [PERIOD_WIDTH-1:0] cnt_d;
    logic                    w_wrap;

    always_comb begin
        // ">=" keeps the counter from running away if it is ever above the
        // last count value; a PERIOD write clears it anyway.
        w_wrap  = (period != '0) && (cnt_q >= (period - PERIOD_WIDTH'(1)));
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!(en && blink_en)) begin
            // Parked state: restart a fresh "LEDs on" half-period next time
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (period_wr) begin
            // A PERIOD write always restarts the count but a coincident
            // wrap still flips the phase.
            cnt_d = '0;
            if (w_wrap) begin
                phase_d = ~phase_q;
            end
        end else if (w_wrap) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else if (period != '0) begin
            cnt_d = cnt_q + PERIOD_WIDTH'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    assign cnt   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/apb_led_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_led_slave
// Description : APB completer for the LED slot. Register bank (CTRL, DATA,
//               PERIOD, STATUS) with byte-strobed writes, programmable wait
//               states and a registered LED output with hardware blinking.
// Ports       : pclk, presetn (sync, active-low)
//               psel, penable, pwrite, paddr, pwdata, pstrb - APB request
//               pready_o, prdata_o, pslverr_o               - APB response
//               led_o                                       - LED drive
// Revision    : 1.0 - initial release
// ============================================================================
module apb_led_slave
    import apb_led_pkg::*;
#(
    parameter int PADDR_WIDTH  = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int LED_NUM      = 8,
    parameter int WAIT_STATES  = 0,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [PADDR_WIDTH-1:0]  paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready_o,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pslverr_o,
    output logic [LED_NUM-1:0]      led_o
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t                  state_q;
    state_t                  state_d;
    logic [3:0]              wcnt_q;
    logic [3:0]              wcnt_d;
    logic [1:0]              ctrl_q;
    logic [1:0]              ctrl_d;
    logic [LED_NUM-1:0]      data_q;
    logic [LED_NUM-1:0]      data_d;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] period_d;
    logic [LED_NUM-1:0]      led_q;
    logic [LED_NUM-1:0]      led_d;

    logic                    w_setup;
    logic                    w_access;
    logic                    w_unmapped;
    logic                    w_ready;
    logic                    w_commit;
    logic                    w_period_wr;
    logic [DATA_WIDTH-1:0]   w_rd_mux;
    logic                    w_phase;
    logic [PERIOD_WIDTH-1:0] w_cnt;
    logic                    w_unused_ok;

    assign w_setup    = psel & ~penable;
    assign w_access   = psel &  penable;
    assign w_unmapped = |paddr[PADDR_WIDTH-1:4];

    // Byte-lane bits not backed by a register and the ignored address LSBs
    assign w_unused_ok = ^{paddr[1:0], pwdata, pstrb};

    // ------------------------------------------------------------------
    // Handshake FSM; pready is combinational so a zero-wait-state access
    // completes in its first access cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        w_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_setup) begin
                    state_d = ST_WAIT;
                    wcnt_d  = 4'd0;
                end else if (w_access && (WS == 4'd0)) begin
                    w_ready = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    // Initiator abandoned the transfer
                    state_d = ST_IDLE;
                    wcnt_d  = 4'd0;
                end else if (!penable) begin
                    wcnt_d = 4'd0;
                end else if (wcnt_q == WS) begin
                    w_ready = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (w_setup) begin
                    state_d = ST_WAIT;
                    wcnt_d  = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = 4'd0;
            end
        endcase
        // Never report completion while reset is being applied
        if (!presetn) begin
            w_ready = 1'b0;
        end
    end

    assign w_commit = w_ready & pwrite & ~w_unmapped;

    // ------------------------------------------------------------------
    // Register write path with per-byte strobes
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d      = ctrl_q;
        data_d      = data_q;
        period_d    = period_q;
        w_period_wr = 1'b0;
        if (w_commit) begin
            case (paddr[3:2])
                REG_CTRL[3:2]: begin
                    if (pstrb[0]) begin
                        ctrl_d = pwdata[1:0];
                    end
                end
                REG_DATA[3:2]: begin
                    for (int b = 0; b < LED_NUM; b++) begin
                        if (pstrb[b/8]) begin
                            data_d[b] = pwdata[b];
                        end
                    end
                end
                REG_PERIOD[3:2]: begin
                    w_period_wr = 1'b1;
                    for (int b = 0; b < PERIOD_WIDTH; b++) begin
                        if (pstrb[b/8]) begin
                            period_d[b] = pwdata[b];
                        end
                    end
                end
                default: begin
                    // STATUS is read-only
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read mux; unused bits and unmapped addresses read as zero
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = '0;
        if (!w_unmapped) begin
            case (paddr[3:2])
                REG_CTRL[3:2]:   w_rd_mux[1:0] = ctrl_q;
                REG_DATA[3:2]:   w_rd_mux[LED_NUM-1:0] = data_q;
                REG_PERIOD[3:2]: w_rd_mux[PERIOD_WIDTH-1:0] = period_q;
                default: begin
                    w_rd_mux[0] = w_phase;
                    for (int i = 0; i < PERIOD_WIDTH; i++) begin
                        if (i + 1 < DATA_WIDTH) begin
                            w_rd_mux[i+1] = w_cnt[i];
                        end
                    end
                end
            endcase
        end
    end

    assign pready_o  = w_ready;
    assign prdata_o  = w_ready ? w_rd_mux : '0;
    assign pslverr_o = w_ready & w_unmapped;

    // ------------------------------------------------------------------
    // LED drive
    // ------------------------------------------------------------------
    always_comb begin
        led_d = '0;
        if (ctrl_q[CTRL_EN_BIT]) begin
            if (!ctrl_q[CTRL_BLINK_BIT] || w_phase) begin
                led_d = data_q;
            end
        end
    end

    assign led_o = led_q;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= 4'd0;
            ctrl_q   <= 2'b00;
            data_q   <= '0;
            period_q <= '0;
            led_q    <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            ctrl_q   <= ctrl_d;
            data_q   <= data_d;
            period_q <= period_d;
            led_q    <= led_d;
        end
    end

    apb_led_blink #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_blink (
        .pclk      (pclk),
        .presetn   (presetn),
        .en        (ctrl_q[CTRL_EN_BIT]),
        .blink_en  (ctrl_q[CTRL_BLINK_BIT]),
        .period    (period_q),
        .period_wr (w_period_wr),
        .phase     (w_phase),
        .cnt       (w_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_apb_led_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_led_slave
// Description : Self-checking bench for apb_led_slave. Three instances with
//               0, 3 and 5 wait states share one APB bus, each with its own
//               psel. A table of transfers covers the register map on the
//               zero-wait instance; hand sequences cover wait states, strobes,
//               LED drive, blinking, abort and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_led_slave;

    logic        clk;
    logic        presetn;
    logic [2:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    logic [2:0]  pready_v;
    logic [31:0] prdata_v [3];
    logic [2:0]  pslverr_v;
    logic [7:0]  led_v [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_led_slave #(.WAIT_STATES(0)) dut0 (
        .pclk(clk), .presetn(presetn), .psel(psel_v[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready_o(pready_v[0]), .prdata_o(prdata_v[0]),
        .pslverr_o(pslverr_v[0]), .led_o(led_v[0])
    );
    apb_led_slave #(.WAIT_STATES(3)) dut3 (
        .pclk(clk), .presetn(presetn), .psel(psel_v[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready_o(pready_v[1]), .prdata_o(prdata_v[1]),
        .pslverr_o(pslverr_v[1]), .led_o(led_v[1])
    );
    apb_led_slave #(.WAIT_STATES(5)) dut5 (
        .pclk(clk), .presetn(presetn), .psel(psel_v[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready_o(pready_v[2]), .prdata_o(prdata_v[2]),
        .pslverr_o(pslverr_v[2]), .led_o(led_v[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One APB transfer on instance d; waits = number of access cycles with
    // pready low before completion.
    task automatic apb_xfer(input int d, input logic wr, input logic [15:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output logic err, output int waits);
        int n;
        @(posedge clk); #1;
        psel_v    = 3'b000;
        psel_v[d] = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = addr;
        pwdata    = wdata;
        pstrb     = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        n = 0;
        while (!pready_v[d] && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        if (!pready_v[d]) begin
            checks++;
            errors++;
            $display("FAIL pready_timeout: no pready after %0d cycles on instance %0d", n, d);
        end
        rdata    = prdata_v[d];
        err      = pslverr_v[d];
        waits    = n;
        last_cyc = cyc;
        @(posedge clk); #1;
        psel_v  = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic wr_reg(input int d, input logic [15:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb);
        logic [31:0] rd;
        logic        er;
        int          w;
        apb_xfer(d, 1'b1, addr, wdata, strb, rd, er, w);
        check("wr_err", {31'd0, er}, 32'd0);
    endtask

    task automatic rd_reg(input int d, input logic [15:0] addr, output logic [31:0] rd);
        logic er;
        int   w;
        apb_xfer(d, 1'b0, addr, 32'd0, 4'h0, rd, er, w);
    endtask

    // Blink model for PERIOD=4 started from a parked engine at edge k=0
    function automatic logic ph_fn(input int k);
        return ((k / 4) % 2) == 0;
    endfunction

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [22];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w;
        int          cyc_e0;
        int          k;
        logic        frozen_ph;

        vecs[0]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 16'h0004, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 16'h0008, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 16'h000C, 32'h0,        4'h0, 32'h1,        1'b0};
        vecs[4]  = '{1'b1, 16'h0008, 32'h00123456, 4'hF, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 16'h0008, 32'h0,        4'h0, 32'h00123456, 1'b0};
        vecs[6]  = '{1'b1, 16'h0008, 32'hFFFFFFFF, 4'h2, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 16'h0008, 32'h0,        4'h0, 32'h0012FF56, 1'b0};
        vecs[8]  = '{1'b1, 16'h0008, 32'h00000000, 4'h0, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 16'h0008, 32'h0,        4'h0, 32'h0012FF56, 1'b0};
        vecs[10] = '{1'b1, 16'h0004, 32'hFFFFFF5A, 4'hF, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 16'h0004, 32'h0,        4'h0, 32'h0000005A, 1'b0};
        vecs[12] = '{1'b1, 16'h0000, 32'hFFFFFFFC, 4'hF, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h0,        1'b0};
        vecs[14] = '{1'b1, 16'h0010, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[15] = '{1'b1, 16'h0104, 32'h00000000, 4'hF, 32'h0,        1'b1};
        vecs[16] = '{1'b0, 16'h0010, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[17] = '{1'b0, 16'h0100, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[18] = '{1'b0, 16'h0004, 32'h0,        4'h0, 32'h0000005A, 1'b0};
        vecs[19] = '{1'b1, 16'h000C, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
        vecs[20] = '{1'b0, 16'h000C, 32'h0,        4'h0, 32'h00000001, 1'b0};
        vecs[21] = '{1'b0, 16'h0007, 32'h0,        4'h0, 32'h0000005A, 1'b0};

        presetn = 1'b0;
        psel_v  = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", {31'd0, pready_v[0]}, 32'd0);
        check("rst_prdata", prdata_v[0], 32'd0);
        check("rst_pslverr", {31'd0, pslverr_v[0]}, 32'd0);
        check("rst_led", {24'd0, led_v[0]}, 32'd0);
        presetn = 1'b1;

        // Register map, strobes and unmapped accesses (zero wait states)
        for (int i = 0; i < 22; i++) begin
            apb_xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, w);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_waits", i), w, 32'd0);
            if (!vecs[i].wr) begin
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            end
        end
        check("tbl_led", {24'd0, led_v[0]}, 32'd0);

        // Three wait states
        apb_xfer(1, 1'b1, 16'h0004, 32'h000000A5, 4'b0001, rd, er, w);
        check("ws3_wr_waits", w, 32'd3);
        check("ws3_wr_err", {31'd0, er}, 32'd0);
        apb_xfer(1, 1'b0, 16'h0004, 32'h0, 4'h0, rd, er, w);
        check("ws3_rd_waits", w, 32'd3);
        check("ws3_rd_data", rd, 32'hA5);
        wr_reg(1, 16'h0004, 32'h0000FF00, 4'b0010);
        rd_reg(1, 16'h0004, rd);
        check("ws3_strb1", rd, 32'hA5);
        wr_reg(1, 16'h0004, 32'h000000FF, 4'b0010);
        rd_reg(1, 16'h0004, rd);
        check("ws3_strb0_off", rd, 32'hA5);

        // Static LED drive
        wr_reg(0, 16'h0004, 32'h3C, 4'hF);
        wr_reg(0, 16'h0000, 32'h1, 4'hF);
        @(posedge clk); #1;
        check("led_on", {24'd0, led_v[0]}, 32'h3C);
        wr_reg(0, 16'h0000, 32'h0, 4'hF);
        @(posedge clk); #1;
        check("led_off", {24'd0, led_v[0]}, 32'h00);
        wr_reg(0, 16'h0000, 32'h1, 4'hF);
        wr_reg(0, 16'h0008, 32'h4, 4'hF);

        // Blinking with PERIOD=4
        wr_reg(0, 16'h0000, 32'h3, 4'hF);
        cyc_e0 = cyc;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            k = cyc - cyc_e0;
            check($sformatf("blink_led_k%0d", k), {24'd0, led_v[0]},
                  ph_fn(k - 1) ? 32'h3C : 32'h0);
        end
        for (int i = 0; i < 5; i++) begin
            rd_reg(0, 16'h000C, rd);
            k = last_cyc - cyc_e0;
            check($sformatf("blink_status_k%0d", k), rd,
                  (32'(k % 4) << 1) | {31'd0, ph_fn(k)});
        end

        // PERIOD=0 freezes cnt at 0 and the phase where it was
        wr_reg(0, 16'h0008, 32'h0, 4'hF);
        frozen_ph = ph_fn(cyc - cyc_e0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("freeze_led", {24'd0, led_v[0]}, frozen_ph ? 32'h3C : 32'h0);
        end
        rd_reg(0, 16'h000C, rd);
        check("freeze_status", rd, {31'd0, frozen_ph});

        // Abort during wait states: no update, next transfer normal
        @(posedge clk); #1;
        psel_v  = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 16'h0004;
        pwdata  = 32'hFF;
        pstrb   = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        check("abort_pready1", {31'd0, pready_v[2]}, 32'd0);
        @(posedge clk); #2;
        check("abort_pready2", {31'd0, pready_v[2]}, 32'd0);
        @(posedge clk); #1;
        psel_v  = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        apb_xfer(2, 1'b0, 16'h0004, 32'h0, 4'h0, rd, er, w);
        check("abort_data", rd, 32'h0);
        check("abort_rd_waits", w, 32'd5);
        apb_xfer(2, 1'b1, 16'h0004, 32'h77, 4'hF, rd, er, w);
        check("post_abort_wr_waits", w, 32'd5);
        rd_reg(2, 16'h0004, rd);
        check("post_abort_data", rd, 32'h77);

        // Reset in the middle of blinking
        wr_reg(0, 16'h0008, 32'h4, 4'hF);
        wr_reg(0, 16'h0000, 32'h1, 4'hF);
        wr_reg(0, 16'h0000, 32'h3, 4'hF);
        @(posedge clk); #1;
        check("pre_rst_led", {24'd0, led_v[0]}, 32'h3C);
        presetn = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_led", {24'd0, led_v[0]}, 32'h0);
        presetn = 1'b1;
        rd_reg(0, 16'h000C, rd);
        check("post_rst_status", rd, 32'h1);
        rd_reg(0, 16'h0000, rd);
        check("post_rst_ctrl", rd, 32'h0);
        rd_reg(0, 16'h0004, rd);
        check("post_rst_data", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
